pmp_seq_checker: RTL and testbench

PMP_SEQ_CHECKER -- requirements
Module: pmp_seq_checker

---
 rtl/pmp_seq_checker.sv | 163 ++++++++++++++++
 tb/tb_pmp_seq_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_seq_checker.sv
// pmp_seq_checker: sequential PMP check, one entry per cycle in ascending order, first match wins.
// Latency: entry k evaluated k+1 cycles after accept, result registered on that edge; PMP_ENTRIES cycles worst case.
// Backpressure: ReqReady only while IDLE; result held in DONE until RspValid & RspReady is sampled.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset
//   ReqValid/ReqReady   - check request handshake; ReqPAdr, ReqRead/Write/Execute, ReqMachine latched on accept
//   PMPCFG_ARRAY_REGW   - per-entry cfg {L,2'b0,A[1:0],X,W,R}
//   PMPADDR_ARRAY_REGW  - per-entry pmpaddr (PA[PA_BITS-1:2] granularity)
//   CfgChange           - PMP CSR write retiring; restarts an in-flight scan
//   RspValid/RspReady   - result handshake; RspFault, RspMatch, RspEntry
//
// Build option: define PMP_SEQ_TOR_EN to enable TOR (A=01) matching. When undefined, TOR entries
// behave as OFF and neither the TOR comparator nor the previous-address register is built.
module pmp_seq_checker #(
    parameter int PMP_ENTRIES = 16,
    parameter int PA_BITS     = 56
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ReqValid,
    output logic                                  ReqReady,
    input  logic [PA_BITS-1:0]                    ReqPAdr,
    input  logic                                  ReqRead,
    input  logic                                  ReqWrite,
    input  logic                                  ReqExecute,
    input  logic                                  ReqMachine,
    input  logic [PMP_ENTRIES-1:0][7:0]           PMPCFG_ARRAY_REGW,
    input  logic [PMP_ENTRIES-1:0][PA_BITS-3:0]   PMPADDR_ARRAY_REGW,
    input  logic                                  CfgChange,
    output logic                                  RspValid,
    input  logic                                  RspReady,
    output logic                                  RspFault,
    output logic                                  RspMatch,
    output logic [5:0]                            RspEntry
);

    localparam int            AW   = PA_BITS - 2;
    localparam logic [5:0]    LAST = 6'(PMP_ENTRIES - 1);
    localparam logic [AW-1:0] ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state;
    logic [5:0]    cnt;
    logic [AW-1:0] pa_q;
    logic [2:0]    acc_q;      // {X,W,R}, one-hot
    logic          mach_q;
`ifdef PMP_SEQ_TOR_EN
    logic [AW-1:0] prev_addr_q; // pmpaddr of entry cnt-1 (0 for entry 0)
`endif

    logic [7:0]    cur_cfg;
    logic [AW-1:0] cur_addr;
    logic          hit;
    logic          perm_ok;
    logic          deny;
    logic          unused_bits;

    // Byte offset of the address and the reserved cfg bits play no part in the check.
    assign unused_bits = ^{ReqPAdr[1:0], cur_cfg[6:5]};

    // Select the entry under evaluation.
    always_comb begin
        cur_cfg  = '0;
        cur_addr = '0;
        for (int i = 0; i < PMP_ENTRIES; i++) begin
            if (cnt == 6'(i)) begin
                cur_cfg  = PMPCFG_ARRAY_REGW[i];
                cur_addr = PMPADDR_ARRAY_REGW[i];
            end
        end
    end

    // NAPOT: addr ^ (addr+1) sets the trailing ones plus the lowest zero; those bits are don't-care.
    always_comb begin
        hit = 1'b0;
        case (cur_cfg[4:3])
            2'b10:   hit = (pa_q == cur_addr);
            2'b11:   hit = ((pa_q ^ cur_addr) & ~(cur_addr ^ (cur_addr + ONE))) == '0;
`ifdef PMP_SEQ_TOR_EN
            2'b01:   hit = (pa_q >= prev_addr_q) && (pa_q < cur_addr);
`endif
            default: hit = 1'b0;
        endcase
    end

    assign perm_ok = |(acc_q & cur_cfg[2:0]);
    assign deny    = (~mach_q | cur_cfg[7]) & ~perm_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pa_q        <= '0;
            acc_q       <= '0;
            mach_q      <= 1'b0;
            ReqReady    <= 1'b0;
            RspValid    <= 1'b0;
            RspFault    <= 1'b0;
            RspMatch    <= 1'b0;
            RspEntry    <= '0;
`ifdef PMP_SEQ_TOR_EN
            prev_addr_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ReqReady <= 1'b1;
                    if (ReqValid && ReqReady) begin
                        pa_q        <= ReqPAdr[PA_BITS-1:2];
                        acc_q       <= {ReqExecute, ReqWrite, ReqRead};
                        mach_q      <= ReqMachine;
                        cnt         <= '0;
`ifdef PMP_SEQ_TOR_EN
                        prev_addr_q <= '0;
`endif
                        ReqReady    <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    // A config write invalidates any partial result, including a hit this cycle.
                    if (CfgChange) begin
                        cnt         <= '0;
`ifdef PMP_SEQ_TOR_EN
                        prev_addr_q <= '0;
`endif
                    end else if (hit) begin
                        RspValid <= 1'b1;
                        RspMatch <= 1'b1;
                        RspEntry <= cnt;
                        RspFault <= deny;
                        state    <= DONE;
                    end else if (cnt == LAST) begin
                        RspValid <= 1'b1;
                        RspMatch <= 1'b0;
                        RspEntry <= '0;
                        RspFault <= ~mach_q;
                        state    <= DONE;
                    end else begin
                        cnt         <= cnt + 6'd1;
`ifdef PMP_SEQ_TOR_EN
                        prev_addr_q <= cur_addr;
`endif
                    end
                end
                DONE: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        RspMatch <= 1'b0;
                        RspEntry <= '0;
                        RspFault <= 1'b0;
                        ReqReady <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_seq_checker.sv
// tb_pmp_seq_checker: directed vectors for pmp_seq_checker with a cycle-level reference model.
// Latency: n/a (bench).
// Backpressure: bench drives RspReady low by default and pulses it to consume each result.
module tb_pmp_seq_checker;

    localparam int N = 16;
`ifdef PMP_SEQ_TOR_EN
    localparam bit TOR_EN = 1'b1;
`else
    localparam bit TOR_EN = 1'b0;
`endif
    localparam logic [2:0] AR = 3'b001;
    localparam logic [2:0] AW = 3'b010;
    localparam logic [2:0] AX = 3'b100;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  ReqValid = 1'b0;
    logic                  ReqReady;
    logic [55:0]           ReqPAdr = '0;
    logic                  ReqRead = 1'b0;
    logic                  ReqWrite = 1'b0;
    logic                  ReqExecute = 1'b0;
    logic                  ReqMachine = 1'b0;
    logic [N-1:0][7:0]     cfg_arr = '0;
    logic [N-1:0][53:0]    addr_arr = '0;
    logic                  CfgChange = 1'b0;
    logic                  RspValid;
    logic                  RspReady = 1'b0;
    logic                  RspFault;
    logic                  RspMatch;
    logic [5:0]            RspEntry;

    int n_run = 0;
    int n_fail = 0;
    bit done = 1'b0;

    pmp_seq_checker #(.PMP_ENTRIES(N), .PA_BITS(56)) dut (
        .clk(clk), .reset(reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqPAdr(ReqPAdr),
        .ReqRead(ReqRead), .ReqWrite(ReqWrite), .ReqExecute(ReqExecute), .ReqMachine(ReqMachine),
        .PMPCFG_ARRAY_REGW(cfg_arr), .PMPADDR_ARRAY_REGW(addr_arr), .CfgChange(CfgChange),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspFault(RspFault), .RspMatch(RspMatch), .RspEntry(RspEntry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference check of one access against the whole table: returns {fault, match, last entry scanned}.
    function automatic logic [7:0] model_eval(input logic [55:0] pa, input logic [2:0] acc, input logic mach);
        logic [53:0] w, ad, lo;
        logic        hit;
        int          t;
        w = pa[55:2];
        for (int i = 0; i < N; i++) begin
            ad = addr_arr[i];
            if (i == 0) lo = '0;
            else        lo = addr_arr[i-1];
            hit = 1'b0;
            case (cfg_arr[i][4:3])
                2'b10: hit = (w == ad);
                2'b11: begin
                    t = 0;
                    while (t < 54 && ad[t]) t++;
                    hit = ((w >> (t + 1)) == (ad >> (t + 1)));
                end
                2'b01: hit = TOR_EN && (w >= lo) && (w < ad);
                default: hit = 1'b0;
            endcase
            if (hit)
                return {(!mach || cfg_arr[i][7]) && ((acc & cfg_arr[i][2:0]) == 3'b000), 1'b1, 6'(i)};
        end
        return {!mach, 1'b0, 6'(N - 1)};
    endfunction

    // Timing model: result due k+1 edges after accept (or after the edge that sampled CfgChange).
    int          ph = 0;       // 0 idle, 1 scanning, 2 result pending
    int          m_ready = 0;
    int          m_valid = 0;
    int          cyc = 0;
    int          start = 0;
    logic [7:0]  r_res = '0;
    logic [55:0] q_pa = '0;
    logic [2:0]  q_acc = '0;
    logic        q_m = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            ph <= 0; m_ready <= 0; m_valid <= 0; cyc <= 0;
        end else begin
            cyc <= cyc + 1;
            case (ph)
                0: if (m_ready != 0 && ReqValid) begin
                        q_pa    <= ReqPAdr;
                        q_acc   <= {ReqExecute, ReqWrite, ReqRead};
                        q_m     <= ReqMachine;
                        r_res   <= model_eval(ReqPAdr, {ReqExecute, ReqWrite, ReqRead}, ReqMachine);
                        start   <= cyc;
                        m_ready <= 0;
                        ph      <= 1;
                    end else begin
                        m_ready <= 1;
                    end
                1: if (CfgChange) begin
                        r_res <= model_eval(q_pa, q_acc, q_m);
                        start <= cyc;
                    end else if (cyc == start + 1 + int'(r_res[5:0])) begin
                        m_valid <= 1;
                        ph      <= 2;
                    end
                default: if (RspReady) begin
                        m_valid <= 0;
                        m_ready <= 1;
                        ph      <= 0;
                    end
            endcase
        end
    end

    // Issue one request, optionally pulse CfgChange so it is sampled cc_at edges after accept,
    // then check latency (edges from accept to RspValid) and the result against literals.
    task automatic run_req(input string nm, input logic [55:0] pa, input logic [2:0] acc, input logic mach,
                           input int cc_at, input int e_lat, input int e_m, input int e_e, input int e_f);
        int n;
        bit got;
        @(posedge clk); #1;
        ReqValid = 1'b1; ReqPAdr = pa; {ReqExecute, ReqWrite, ReqRead} = acc; ReqMachine = mach;
        @(posedge clk); #1;
        // Scramble request inputs; only the latched copy may matter from here on.
        ReqValid = 1'b0; ReqPAdr = ~pa; {ReqExecute, ReqWrite, ReqRead} = {acc[1:0], acc[2]}; ReqMachine = ~mach;
        n = 0; got = 1'b0;
        for (int g = 0; g < 200 && !got; g++) begin
            CfgChange = (cc_at > 0) && (n == cc_at - 1);
            @(negedge clk);
            if (RspValid) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        CfgChange = 1'b0;
        chk({nm, "_latency"}, got ? n : -1, e_lat);
        chk({nm, "_match"}, 32'(RspMatch), e_m);
        chk({nm, "_entry"}, 32'(RspEntry), e_e);
        chk({nm, "_fault"}, 32'(RspFault), e_f);
        @(posedge clk); #1; RspReady = 1'b1;
        @(posedge clk); #1; RspReady = 1'b0;
    endtask

    initial begin
        fork
            begin : monitor
                while (!done) begin
                    @(negedge clk);
                    if (reset) begin
                        chk("rst_ReqReady", 32'(ReqReady), 0);
                        chk("rst_RspValid", 32'(RspValid), 0);
                        chk("rst_RspFault", 32'(RspFault), 0);
                        chk("rst_RspMatch", 32'(RspMatch), 0);
                        chk("rst_RspEntry", 32'(RspEntry), 0);
                    end else begin
                        chk("mon_ReqReady", 32'(ReqReady), m_ready);
                        chk("mon_RspValid", 32'(RspValid), m_valid);
                        if (m_valid != 0) begin
                            chk("mon_RspMatch", 32'(RspMatch), 32'(r_res[6]));
                            chk("mon_RspEntry", 32'(RspEntry), r_res[6] ? 32'(r_res[5:0]) : 0);
                            chk("mon_RspFault", 32'(RspFault), 32'(r_res[7]));
                        end
                    end
                end
            end
            begin : stimulus
                int n;
                bit got;
                int seen;
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
                @(negedge clk);
                chk("ready_before_edge", 32'(ReqReady), 0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("ready_after_reset", 32'(ReqReady), 1);
                @(posedge clk); #1;

                // Empty table.
                run_req("off_s", 56'h8000_0000, AR, 1'b0, 0, 16, 0, 0, 1);
                run_req("off_m", 56'h8000_0000, AR, 1'b1, 0, 16, 0, 0, 0);

                // Entry 3 NAPOT over bytes 0x8000_0000..0x8000_0FFF, read-only.
                cfg_arr[3] = 8'h19; addr_arr[3] = 54'h2000_01FF;
                run_req("napot_s_w", 56'h8000_0100, AW, 1'b0, 0, 4, 1, 3, 1);
                run_req("napot_s_r", 56'h8000_0100, AR, 1'b0, 0, 4, 1, 3, 0);
                run_req("napot_top", 56'h8000_0FFC, AR, 1'b0, 0, 4, 1, 3, 0);
                run_req("napot_out", 56'h8000_1000, AR, 1'b0, 0, 16, 0, 0, 1);
                cfg_arr[3] = 8'h99;
                run_req("lock_m_w", 56'h8000_0100, AW, 1'b1, 0, 4, 1, 3, 1);
                cfg_arr[3] = 8'h19;
                run_req("nolock_m_w", 56'h8000_0100, AW, 1'b1, 0, 4, 1, 3, 0);

                // NA4 at entry 2 overlaps entry 3: lowest index wins.
                cfg_arr[2] = 8'h14; addr_arr[2] = 54'h2000_0040;
                run_req("na4_first", 56'h8000_0100, AX, 1'b0, 0, 3, 1, 2, 0);

                // TOR.
                cfg_arr = '0; addr_arr = '0;
                addr_arr[0] = 54'h400; addr_arr[1] = 54'h800; cfg_arr[1] = 8'h0C;
                run_req("tor_hit", 56'h1000, AX, 1'b0, 0, TOR_EN ? 2 : 16, TOR_EN ? 1 : 0, TOR_EN ? 1 : 0, TOR_EN ? 0 : 1);
                run_req("tor_top", 56'h2000, AX, 1'b0, 0, 16, 0, 0, 1);
                cfg_arr[0] = 8'h0C;
                run_req("tor_e0", 56'h10, AX, 1'b0, 0, TOR_EN ? 1 : 16, TOR_EN ? 1 : 0, 0, TOR_EN ? 0 : 1);

                // Entry 5 NA4: restart behaviour.
                cfg_arr = '0; addr_arr = '0;
                cfg_arr[5] = 8'h11; addr_arr[5] = 54'h2000_0040;
                run_req("e5", 56'h8000_0100, AR, 1'b0, 0, 6, 1, 5, 0);
                run_req("cc_restart", 56'h8000_0100, AR, 1'b0, 3, 9, 1, 5, 0);
                run_req("cc_on_match", 56'h8000_0100, AR, 1'b0, 6, 12, 1, 5, 0);

                // Reset mid-scan: request discarded, no result ever appears.
                @(posedge clk); #1;
                ReqValid = 1'b1; ReqPAdr = 56'h8000_0100; {ReqExecute, ReqWrite, ReqRead} = AR; ReqMachine = 1'b0;
                @(posedge clk); #1; ReqValid = 1'b0;
                @(posedge clk); #1; reset = 1'b1;
                @(posedge clk); #1; reset = 1'b0;
                @(negedge clk);
                chk("mid_rst_ready_low", 32'(ReqReady), 0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("mid_rst_ready_high", 32'(ReqReady), 1);
                seen = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (RspValid) seen++;
                end
                chk("mid_rst_no_rsp", seen, 0);

                // Held result with ReqValid kept high for a follow-up request.
                @(posedge clk); #1;
                cfg_arr = '0; addr_arr = '0;
                cfg_arr[3] = 8'h19; addr_arr[3] = 54'h2000_01FF;
                @(posedge clk); #1;
                ReqValid = 1'b1; ReqPAdr = 56'h8000_0100; {ReqExecute, ReqWrite, ReqRead} = AW; ReqMachine = 1'b0;
                @(posedge clk); #1;
                {ReqExecute, ReqWrite, ReqRead} = AR;
                n = 0; got = 1'b0;
                for (int g = 0; g < 200 && !got; g++) begin
                    @(negedge clk);
                    if (RspValid) got = 1'b1;
                    else begin @(posedge clk); #1; n++; end
                end
                chk("hold_latency", got ? n : -1, 4);
                @(posedge clk); #1;
                for (int c = 0; c < 10; c++) begin
                    CfgChange = (c == 4);
                    @(negedge clk);
                    chk("hold_valid", 32'(RspValid), 1);
                    chk("hold_match", 32'(RspMatch), 1);
                    chk("hold_entry", 32'(RspEntry), 3);
                    chk("hold_fault", 32'(RspFault), 1);
                    chk("hold_ready", 32'(ReqReady), 0);
                    @(posedge clk); #1;
                end
                CfgChange = 1'b0;
                RspReady = 1'b1;
                @(posedge clk); #1;
                RspReady = 1'b0;
                n = 0; got = 1'b0;
                for (int g = 0; g < 200 && !got; g++) begin
                    if (n == 1) ReqValid = 1'b0;
                    @(negedge clk);
                    if (RspValid) got = 1'b1;
                    else begin @(posedge clk); #1; n++; end
                end
                ReqValid = 1'b0;
                chk("reaccept_latency", got ? n : -1, 5);
                chk("reaccept_entry", 32'(RspEntry), 3);
                chk("reaccept_fault", 32'(RspFault), 0);
                @(posedge clk); #1; RspReady = 1'b1;
                @(posedge clk); #1; RspReady = 1'b0;
                repeat (3) @(posedge clk);
                #1 done = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
